// File: rtl/set_count_n.sv
// Grid-point set counter: scans a GRID x GRID lattice one point per cycle and
// counts the points whose circle-membership pattern is selected by a truth-table mask.
module set_count_n #(
    parameter int GRID    = 8,
    parameter int NCIRC   = 3,
    parameter int COORD_W = 4,
    parameter int R_W     = 4,
    parameter int CNT_W   = $clog2(GRID*GRID+1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NCIRC*2*COORD_W-1:0]   central,
    input  logic [NCIRC*R_W-1:0]         radius,
    input  logic [2**NCIRC-1:0]          mask,
    output logic                         busy,
    output logic                         valid,
    output logic [CNT_W-1:0]             candidate
);

    localparam int XW     = $clog2(GRID+1);
    localparam int DW     = ((XW > COORD_W) ? XW : COORD_W) + 1;
    localparam int SQ_W   = 2*DW;
    localparam int SUM_W  = SQ_W + 1;
    localparam int RR_W   = 2*R_W;
    localparam int CMP_W  = (SUM_W > RR_W) ? SUM_W : RR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_LAST = XW'(GRID);

    logic [1:0]                     state_q, state_d;
    logic [XW-1:0]                  x_q, y_q;
    logic [NCIRC*2*COORD_W-1:0]     central_q;
    logic [NCIRC*R_W-1:0]           radius_q;
    logic [2**NCIRC-1:0]            mask_q;
    logic                           s1_valid_q;
    logic [NCIRC-1:0]               s1_mem_q;
    logic [NCIRC-1:0]               mem_d;
    logic [CNT_W-1:0]               cnt_q;
    logic                           accept;
    logic                           last_point;

    assign accept     = (state_q == S_IDLE) && en;
    assign last_point = (x_q == X_LAST) && (y_q == X_LAST);

    // Exact membership test per circle; magnitudes are squared unsigned so no term can overflow.
    for (genvar k = 0; k < NCIRC; k++) begin : g_circ
        logic [COORD_W-1:0]   cx, cy;
        logic [R_W-1:0]       r;
        logic signed [DW-1:0] dx, dy;
        logic [DW-1:0]        adx, ady;
        logic [SQ_W-1:0]      dx2, dy2;
        logic [CMP_W-1:0]     dist2, r2;

        assign cx  = central_q[(NCIRC-1-k)*2*COORD_W + COORD_W +: COORD_W];
        assign cy  = central_q[(NCIRC-1-k)*2*COORD_W +: COORD_W];
        assign r   = radius_q[(NCIRC-1-k)*R_W +: R_W];

        assign dx  = DW'(x_q) - DW'(cx);
        assign dy  = DW'(y_q) - DW'(cy);
        assign adx = dx[DW-1] ? DW'(-dx) : DW'(dx);
        assign ady = dy[DW-1] ? DW'(-dy) : DW'(dy);
        assign dx2 = SQ_W'(adx) * SQ_W'(adx);
        assign dy2 = SQ_W'(ady) * SQ_W'(ady);

        assign dist2 = CMP_W'(dx2) + CMP_W'(dy2);
        assign r2    = CMP_W'(r) * CMP_W'(r);

        assign mem_d[k] = (dist2 <= r2);
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (en) state_d = S_SCAN;
            S_SCAN:  if (last_point) state_d = S_DRAIN;
            S_DRAIN: if (!s1_valid_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            state_q    <= S_IDLE;
            x_q        <= X_ONE;
            y_q        <= X_ONE;
            s1_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= (state_q == S_SCAN);

            if (accept) begin
                x_q <= X_ONE;
                y_q <= X_ONE;
            end else if (state_q == S_SCAN) begin
                if (y_q == X_LAST) begin
                    y_q <= X_ONE;
                    x_q <= x_q + X_ONE;
                end else begin
                    y_q <= y_q + X_ONE;
                end
            end

            if (accept) begin
                cnt_q <= '0;
            end else if (s1_valid_q && mask_q[s1_mem_q]) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: pure datapath registers carry no reset; they are always written before any valid flag consumes them.
        if (accept) begin
            central_q <= central;
            radius_q  <= radius;
            mask_q    <= mask;
        end
        s1_mem_q <= mem_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign valid     = (state_q == S_DONE);
    assign candidate = cnt_q;

endmodule

// File: tb/tb_set_count_n.sv
// Bench for set_count_n: a lattice-counting reference model checked every cycle,
// plus directed jobs with hand-computed counts and latencies.
module tb_set_count_n;

    localparam int GRID    = 8;
    localparam int NCIRC   = 3;
    localparam int COORD_W = 4;
    localparam int R_W     = 4;
    localparam int CNT_W   = $clog2(GRID*GRID+1);
    localparam int LAT     = 66;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       en;
    logic [NCIRC*2*COORD_W-1:0] central;
    logic [NCIRC*R_W-1:0]       radius;
    logic [2**NCIRC-1:0]        mask;
    logic                       busy;
    logic                       valid;
    logic [CNT_W-1:0]           candidate;

    int checks   = 0;
    int failures = 0;

    set_count_n #(
        .GRID(GRID), .NCIRC(NCIRC), .COORD_W(COORD_W), .R_W(R_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mask(mask), .busy(busy), .valid(valid), .candidate(candidate)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Brute-force count over the lattice, straight from the membership and mask rules.
    function automatic int count_pts(input logic [23:0] c, input logic [11:0] r, input logic [7:0] m);
        int cnt = 0;
        for (int x = 1; x <= GRID; x++) begin
            for (int y = 1; y <= GRID; y++) begin
                int sel = 0;
                for (int k = 0; k < NCIRC; k++) begin
                    int cx = int'(c[(NCIRC-1-k)*8 + 4 +: 4]);
                    int cy = int'(c[(NCIRC-1-k)*8 +: 4]);
                    int rr = int'(r[(NCIRC-1-k)*4 +: 4]);
                    if ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rr*rr) sel |= (1 << k);
                end
                if (m[sel]) cnt++;
            end
        end
        return cnt;
    endfunction

    // Model: m_k counts edges since the accept edge, -1 when idle.
    int m_k     = -1;
    int m_final = 0;
    int m_cand  = 0;
    int m_prev  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_k    = -1;
            m_cand = 0;
        end else if (m_k < 0) begin
            if (en) begin
                m_final = count_pts(central, radius, mask);
                m_k     = 0;
                m_cand  = 0;
            end
        end else begin
            m_k++;
            if (m_k == LAT + 1) begin
                m_k    = -1;
                m_cand = m_final;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", int'(busy), int'(m_k >= 0));
        check("valid", int'(valid), int'(m_k == LAT));
        if (m_k < 0) begin
            check("cand_idle", int'(candidate), m_cand);
        end else if (m_k == 0) begin
            check("cand_clear", int'(candidate), 0);
            m_prev = 0;
        end else if (m_k == LAT) begin
            check("cand_final", int'(candidate), m_final);
        end else begin
            check("cand_monotonic", int'(int'(candidate) >= m_prev && int'(candidate) <= m_final), 1);
            m_prev = int'(candidate);
        end
    end

    // Pulses en for one accept edge and returns at the first sample after it.
    task automatic start(input logic [23:0] c, input logic [11:0] r, input logic [7:0] m);
        @(negedge clk);
        central = c;
        radius  = r;
        mask    = m;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Waits for valid (bounded), checks latency and count; optional stray en pulses or held en.
    task automatic finish(input int exp, input string name, input int pa, input int pb, input bit hold);
        logic [23:0] c0 = central;
        logic [11:0] r0 = radius;
        logic [7:0]  k0 = mask;
        int n = 0;
        while (valid !== 1'b1 && n < 100) begin
            if (n == pa || n == pb) begin
                en = 1'b1; central = ~c0; radius = ~r0; mask = ~k0;
            end else begin
                en = hold && (n >= 60); central = c0; radius = r0; mask = k0;
            end
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, LAT);
        check({name, "_count"}, int'(candidate), exp);
        if (!hold) en = 1'b0;
        @(negedge clk);
        check({name, "_busy_fall"}, int'(busy), 0);
        if (hold) begin
            @(negedge clk);
            check({name, "_reaccept"}, int'(busy), 1);
            en = 1'b0;
        end
    endtask

    initial begin
        int vcount;
        rst = 1'b1; en = 1'b0; central = '0; radius = '0; mask = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_cand", int'(candidate), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        start(24'h440000, 12'h200, 8'hAA);  finish(13, "circle_a",   -1, -1, 1'b0);
        start(24'h440000, 12'h200, 8'hAA);  finish(13, "en_ignored", 10, 40, 1'b0);
        start(24'h444400, 12'h220, 8'h88);  finish(13, "a_and_b",    -1, -1, 1'b0);
        start(24'h444400, 12'h220, 8'h66);  finish(0,  "a_xor_b",    -1, -1, 1'b0);
        start(24'h000000, 12'h100, 8'hAA);  finish(0,  "origin_r1",  -1, -1, 1'b0);
        start(24'h000000, 12'h200, 8'hAA);  finish(1,  "origin_r2",  -1, -1, 1'b0);
        start(24'h110000, 12'h000, 8'hAA);  finish(1,  "corner_r0",  -1, -1, 1'b0);
        start(24'h880000, 12'hF00, 8'hAA);  finish(64, "big_radius", -1, -1, 1'b0);
        start(24'h357C12, 12'h3A5, 8'hFF);  finish(64, "mask_ff",    -1, -1, 1'b0);
        start(24'h357C12, 12'h3A5, 8'h00);  finish(0,  "mask_00",    -1, -1, 1'b0);
        start(24'h357C12, 12'h3A5, 8'hE8);
        finish(count_pts(24'h357C12, 12'h3A5, 8'hE8), "majority", -1, -1, 1'b0);

        start(24'h440000, 12'h200, 8'hAA);  finish(13, "held_en",    -1, -1, 1'b1);
        finish(13, "held_en_second", -1, -1, 1'b0);

        start(24'h440000, 12'h200, 8'hAA);
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(valid), 0);
        check("abort_cand", int'(candidate), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        vcount = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        start(24'h440000, 12'h200, 8'hAA);  finish(13, "after_abort", -1, -1, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
